reg_file: RTL

General-purpose register file for the SRP16 datapath. It sits directly downstream of the control decoder and executes that stage's register-file strobes each cycle: `read`, `write`, `writu`, `inc`, `dec` and `reg_file_id`. It stores `NUM_REGS` 16-bit registers. It drives the addressed register onto the shared data bus when read, and performs full-word loads, upper-byte loads and in-place increment/decrement with wrap-around.

---
 rtl/srp16_pkg.sv | 35 +++
 rtl/reg_file_if.sv | 31 +++
 rtl/reg_file_cell.sv | 28 ++
 rtl/reg_file.sv | 71 +++++++
 4 files changed

// File: rtl/srp16_pkg.sv
// Constants and op encoding shared by the SRP16 control decoder and the register file.
package srp16_pkg;

   localparam int DATA_W   = 16;
   localparam int REG_ID_W = 6;

   typedef enum logic [2:0] {
      RF_NOP,
      RF_WRITE,
      RF_WRITU,
      RF_INC,
      RF_DEC
   } rf_op_t;

   // Only one mutating op runs per cycle: write beats writu beats inc beats dec.
   function automatic rf_op_t rf_encode(input logic wr, input logic wu,
                                        input logic inc, input logic dec);
      if (wr)
         return RF_WRITE;
      else if (wu)
         return RF_WRITU;
      else if (inc)
         return RF_INC;
      else if (dec)
         return RF_DEC;
      else
         return RF_NOP;
   endfunction

   function automatic logic rf_multi(input logic wr, input logic wu,
                                     input logic inc, input logic dec);
      return (wr & wu) | (wr & inc) | (wr & dec) | (wu & inc) | (wu & dec) | (inc & dec);
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decoder-to-register-file strobe bundle plus the shared data bus and error flags.
interface reg_file_if
   import srp16_pkg::*;
#(
   parameter int ID_W = REG_ID_W
);

   logic              reg_file_read;
   logic              reg_file_write;
   logic              reg_file_writu;
   logic              reg_file_inc;
   logic              reg_file_dec;
   logic [ID_W-1:0]   reg_file_id;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              id_err;
   logic              op_err;

   modport master (
      output reg_file_read, reg_file_write, reg_file_writu,
             reg_file_inc, reg_file_dec, reg_file_id, din,
      input  dout, id_err, op_err
   );

   modport slave (
      input  reg_file_read, reg_file_write, reg_file_writu,
             reg_file_inc, reg_file_dec, reg_file_id, din,
      output dout, id_err, op_err
   );

endinterface

// File: rtl/reg_file_cell.sv
// One 16-bit register that executes the already priority-resolved op when enabled.
module reg_file_cell
   import srp16_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  rf_op_t            op,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] q
);

   // Increment and decrement rely on natural 16-bit truncation for wrap-around.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         case (op)
            RF_WRITE: q <= din;
            RF_WRITU: q <= {din[7:0], q[7:0]};
            RF_INC:   q <= q + DATA_W'(1);
            RF_DEC:   q <= q - DATA_W'(1);
            default:  q <= q;
         endcase
      end
   end

endmodule

// File: rtl/reg_file.sv
// SRP16 general-purpose register file: combinational read onto an OR-merged bus,
// one mutating op per cycle, and sticky id/op error flags.
module reg_file
   import srp16_pkg::*;
#(
   parameter int NUM_REGS = 64,
   parameter int ID_W     = REG_ID_W
)(
   input  logic       clk,
   input  logic       rst_n,
   reg_file_if.slave  bus
);

   localparam logic [ID_W:0] NUM_REGS_L = (ID_W+1)'(NUM_REGS);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rd_data;
   rf_op_t            op;
   logic              id_ok;
   logic              any_strobe;
   logic              multi_op;
   logic              id_err_q;
   logic              op_err_q;

   assign op         = rf_encode(bus.reg_file_write, bus.reg_file_writu,
                                 bus.reg_file_inc, bus.reg_file_dec);
   assign multi_op   = rf_multi(bus.reg_file_write, bus.reg_file_writu,
                                bus.reg_file_inc, bus.reg_file_dec);
   assign id_ok      = ({1'b0, bus.reg_file_id} < NUM_REGS_L);
   assign any_strobe = bus.reg_file_read | bus.reg_file_write | bus.reg_file_writu |
                       bus.reg_file_inc | bus.reg_file_dec;

   // An out-of-range id matches no cell, so such ops change nothing by construction.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
      reg_file_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .en    ((op != RF_NOP) && (bus.reg_file_id == ID_W'(i))),
         .op    (op),
         .din   (bus.din),
         .q     (regs[i])
      );
   end

   // OR-merged select keeps the bus at zero when idle or when the id is out of range.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.reg_file_read && (bus.reg_file_id == ID_W'(i)))
            rd_data = rd_data | regs[i];
      end
   end

   assign bus.dout = rd_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         id_err_q <= 1'b0;
         op_err_q <= 1'b0;
      end else begin
         if (any_strobe && !id_ok)
            id_err_q <= 1'b1;
         if (multi_op)
            op_err_q <= 1'b1;
      end
   end

   assign bus.id_err = id_err_q;
   assign bus.op_err = op_err_q;

endmodule
